psum_acc_seq: RTL and testbench

Parametrised accumulation sequencer between psum memory (pmem) and the SFP accumulator. Given a start pulse, it generates the pmem read address stream, the `acc` strobes and the per-output clear/valid pulses needed to sum K×K×n_tile partial sums into each output pixel. The generalisation is configurable kernel size, input feature-map size and run-time input-channel tile count, with stall support. It replaces externally scripted accumulation addresses.

---
 rtl/psum_acc_seq.sv | 169 ++++++++++++++++
 tb/tb_psum_acc_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_seq.sv
// psum_acc_seq: generates the pmem read stream, SFP acc strobes and per-output
// clear/valid pulses that sum K*K*n_tile partial sums into each output pixel.
module psum_acc_seq #(
   parameter int K      = 3,
   parameter int IN_W   = 6,
   parameter int IN_H   = 6,
   parameter int T_MAX  = 2,
   parameter int ADDR_W = 11
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start,
   input  logic [$clog2(T_MAX+1)-1:0]                    n_tile,
   input  logic                                          hold,
   output logic                                          CEN_pmem,
   output logic                                          WEN_pmem,
   output logic [ADDR_W-1:0]                             A_pmem,
   output logic                                          acc,
   output logic                                          acc_clr,
   output logic                                          out_valid,
   output logic [$clog2((IN_W-K+1)*(IN_H-K+1))-1:0]      onij,
   output logic                                          busy,
   output logic                                          done
);

   localparam int NIJ    = IN_W * IN_H;
   localparam int OUT_W  = IN_W - K + 1;
   localparam int OUT_H  = IN_H - K + 1;
   localparam int NT_W   = $clog2(T_MAX + 1);
   localparam int KC_W   = $clog2(K + 1);
   localparam int OR_W   = $clog2(OUT_H + 1);
   localparam int OC_W   = $clog2(OUT_W + 1);
   localparam int ONIJ_W = $clog2(OUT_W * OUT_H);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_READ,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [NT_W-1:0]   tile_q, tile_d;
   logic [NT_W-1:0]   tlast_q, tlast_d;
   logic [KC_W-1:0]   ki_q, ki_d;
   logic [KC_W-1:0]   kj_q, kj_d;
   logic [OR_W-1:0]   orow_q, orow_d;
   logic [OC_W-1:0]   ocol_q, ocol_d;
   logic              acc_q;
   logic              issue;
   logic [ADDR_W-1:0] kij_a;
   logic [ADDR_W-1:0] addr_a;

   // State, loop counters and the one-cycle-delayed read flag (drives acc).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         tile_q  <= '0;
         tlast_q <= '0;
         ki_q    <= '0;
         kj_q    <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
         acc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         tlast_q <= tlast_d;
         ki_q    <= ki_d;
         kj_q    <= kj_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         acc_q   <= issue;
      end
   end

   // Next-state and counter advance; hold leaves everything frozen.
   always_comb begin
      state_d = state_q;
      tile_d  = tile_q;
      tlast_d = tlast_q;
      ki_d    = ki_q;
      kj_d    = kj_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      if (!hold) begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_CLR;
                  tile_d  = '0;
                  ki_d    = '0;
                  kj_d    = '0;
                  orow_d  = '0;
                  ocol_d  = '0;
                  // stored as last tile index: 0 behaves as 1, over-range clamps
                  if (n_tile == '0)
                     tlast_d = '0;
                  else if (n_tile > NT_W'(T_MAX))
                     tlast_d = NT_W'(T_MAX - 1);
                  else
                     tlast_d = n_tile - NT_W'(1);
               end
            end
            S_CLR: state_d = S_READ;
            S_READ: begin
               if (kj_q == KC_W'(K - 1)) begin
                  kj_d = '0;
                  if (ki_q == KC_W'(K - 1)) begin
                     ki_d = '0;
                     if (tile_q == tlast_q) begin
                        tile_d  = '0;
                        state_d = S_DRAIN;
                     end else begin
                        tile_d = tile_q + NT_W'(1);
                     end
                  end else begin
                     ki_d = ki_q + KC_W'(1);
                  end
               end else begin
                  kj_d = kj_q + KC_W'(1);
               end
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
               state_d = S_CLR;
               if (ocol_q == OC_W'(OUT_W - 1)) begin
                  ocol_d = '0;
                  if (orow_q == OR_W'(OUT_H - 1)) begin
                     orow_d  = '0;
                     state_d = S_DONE;
                  end else begin
                     orow_d = orow_q + OR_W'(1);
                  end
               end else begin
                  ocol_d = ocol_q + OC_W'(1);
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Read address from the current loop indices; all counters are zero when idle.
   always_comb begin
      kij_a  = ADDR_W'(ki_q) * ADDR_W'(K) + ADDR_W'(kj_q);
      addr_a = (ADDR_W'(tile_q) * ADDR_W'(K * K) + kij_a) * ADDR_W'(NIJ)
             + (ADDR_W'(orow_q) + ADDR_W'(ki_q)) * ADDR_W'(IN_W)
             + ADDR_W'(ocol_q) + ADDR_W'(kj_q);
   end

   // Output decode from registered state; hold masks the strobes in the same cycle.
   always_comb begin
      issue     = (state_q == S_READ) && !hold;
      CEN_pmem  = ~issue;
      WEN_pmem  = 1'b1;
      A_pmem    = addr_a;
      acc       = acc_q;
      acc_clr   = (state_q == S_CLR) && !hold;
      out_valid = (state_q == S_OUT) && !hold;
      onij      = ONIJ_W'(orow_q) * ONIJ_W'(OUT_W) + ONIJ_W'(ocol_q);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE) && !hold;
   end

endmodule

// File: tb/tb_psum_acc_seq.sv
// Scoreboard bench for psum_acc_seq at default parameters (K=3, 6x6 input).
module tb_psum_acc_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        hold;
   logic [1:0]  n_tile;
   logic        CEN_pmem, WEN_pmem;
   logic [10:0] A_pmem;
   logic        acc, acc_clr, out_valid;
   logic [3:0]  onij;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   ev_t rd_q[$];
   ev_t acc_q[$];
   ev_t clr_q[$];
   ev_t ov_q[$];
   ev_t dn_q[$];
   ev_t me;

   psum_acc_seq #(.K(3), .IN_W(6), .IN_H(6), .T_MAX(2), .ADDR_W(11)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start),
      .n_tile    (n_tile),
      .hold      (hold),
      .CEN_pmem  (CEN_pmem),
      .WEN_pmem  (WEN_pmem),
      .A_pmem    (A_pmem),
      .acc       (acc),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .onij      (onij),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // cycle index: value seen after a rising edge names the cycle that edge opened
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int mapc(input int n, input int hs, input int hl);
      return (hl > 0 && n >= hs) ? n + hl : n;
   endfunction

   // expected events of one full run started in cycle t0, optional hold window
   task automatic push_run(input int t0, input int nt, input int hs, input int hl);
      int eff, n, p, orow, ocol, tile, kij, ki, kj, r;
      eff = (nt == 0) ? 1 : ((nt > 2) ? 2 : nt);
      n   = 9 * eff;
      p   = n + 3;
      for (int o = 0; o < 16; o++) begin
         orow = o / 4;
         ocol = o % 4;
         clr_q.push_back('{mapc(t0 + 1 + o * p, hs, hl), 1});
         for (int i = 0; i < n; i++) begin
            tile = i / 9;
            kij  = i % 9;
            ki   = kij / 3;
            kj   = kij % 3;
            r    = mapc(t0 + 2 + o * p + i, hs, hl);
            rd_q.push_back('{r, (tile * 9 + kij) * 36 + (orow + ki) * 6 + ocol + kj});
            acc_q.push_back('{r + 1, 1});
         end
         ov_q.push_back('{mapc(t0 + (o + 1) * p, hs, hl), o});
      end
      dn_q.push_back('{mapc(t0 + 16 * p + 1, hs, hl), 1});
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a strobe
   always @(negedge clk) begin
      if (!CEN_pmem) begin
         if (rd_q.size() == 0) check("rd_unexpected", cyc, -1);
         else begin
            me = rd_q.pop_front();
            check("rd_cycle", cyc, me.cyc);
            check("rd_addr", int'(A_pmem), me.val);
            check("rd_wen", int'(WEN_pmem), 1);
         end
      end
      if (acc) begin
         if (acc_q.size() == 0) check("acc_unexpected", cyc, -1);
         else begin
            me = acc_q.pop_front();
            check("acc_cycle", cyc, me.cyc);
         end
      end
      if (acc_clr) begin
         if (clr_q.size() == 0) check("clr_unexpected", cyc, -1);
         else begin
            me = clr_q.pop_front();
            check("clr_cycle", cyc, me.cyc);
         end
      end
      if (out_valid) begin
         if (ov_q.size() == 0) check("ov_unexpected", cyc, -1);
         else begin
            me = ov_q.pop_front();
            check("ov_cycle", cyc, me.cyc);
            check("ov_onij", int'(onij), me.val);
         end
      end
      if (done) begin
         if (dn_q.size() == 0) check("done_unexpected", cyc, -1);
         else begin
            me = dn_q.pop_front();
            check("done_cycle", cyc, me.cyc);
         end
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_cen"},  int'(CEN_pmem),  1);
      check({tag, "_wen"},  int'(WEN_pmem),  1);
      check({tag, "_addr"}, int'(A_pmem),    0);
      check({tag, "_acc"},  int'(acc),       0);
      check({tag, "_clr"},  int'(acc_clr),   0);
      check({tag, "_ov"},   int'(out_valid), 0);
      check({tag, "_onij"}, int'(onij),      0);
      check({tag, "_busy"}, int'(busy),      0);
      check({tag, "_done"}, int'(done),      0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_rd_left"},   rd_q.size(),  0);
      check({tag, "_acc_left"},  acc_q.size(), 0);
      check({tag, "_clr_left"},  clr_q.size(), 0);
      check({tag, "_ov_left"},   ov_q.size(),  0);
      check({tag, "_done_left"}, dn_q.size(),  0);
   endtask

   // one full run; entered and left 1 time unit after a rising edge
   task automatic run(input string tag, input int nt, input int hs_off, input int hl,
                      input bit repulse);
      int t0, eff, done_c;
      eff    = (nt == 0) ? 1 : ((nt > 2) ? 2 : nt);
      done_c = 16 * (9 * eff + 3) + 1 + hl;
      t0     = cyc;
      push_run(t0, nt, t0 + hs_off, hl);
      n_tile = 2'(nt);
      for (int k = 0; k < done_c + 20; k++) begin
         start = (k == 0) || (repulse && (k == 50 || k == done_c));
         hold  = (hl > 0) && (k >= hs_off) && (k < hs_off + hl);
         if (k == 1) check({tag, "_busy_run"}, int'(busy), 1);
         if (k == done_c + 1) check({tag, "_busy_after"}, int'(busy), 0);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      hold  = 1'b0;
      check_drained(tag);
   endtask

   task automatic reset_mid();
      int t0;
      t0 = cyc;
      push_run(t0, 1, 0, 0);
      n_tile = 2'd1;
      for (int k = 0; k < 30; k++) begin
         start = (k == 0);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("rst_mid");
      rd_q.delete();
      acc_q.delete();
      clr_q.delete();
      ov_q.delete();
      dn_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check_idle("rst_hold");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      hold   = 1'b0;
      n_tile = 2'd1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle("idle");

      run("t1_restart", 1, 0, 0, 1'b1);
      run("t2", 2, 0, 0, 1'b0);
      run("t0", 0, 0, 0, 1'b0);
      run("t3clamp", 3, 0, 0, 1'b0);
      run("hold", 1, 5, 3, 1'b0);
      reset_mid();
      run("after_rst", 1, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
